wb_commit: RTL

- Write-back/commit stage of the NPC core. Accepts one retiring instruction per handshake from the execute stage.
- For loads, waits for the LSU read response, then sign- or zero-extends the load data.
- Drives a one-cycle commit strobe set (PC, two CSR ports, GPR) to the register file and to the difftest register bridge.
- Sits directly upstream of the bridge; its outputs map 1:1 onto the bridge's update inputs.

---
 rtl/wb_commit_if.sv | 53 +++++
 rtl/wb_commit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_if.sv
// Handshake and commit bundle between the execute stage, the LSU read port and the
// write-back/commit stage (slave side) feeding the register file and difftest bridge.
interface wb_commit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_next_pc;
   logic             in_gpr_wen;
   logic [4:0]       in_gpr_waddr;
   logic [XLEN-1:0]  in_alu_result;
   logic             in_is_load;
   logic [2:0]       in_load_funct3;
   logic [1:0]       in_addr_low;
   logic             in_csra_wen;
   logic             in_csrb_wen;
   logic [11:0]      in_csra_waddr;
   logic [11:0]      in_csrb_waddr;
   logic [XLEN-1:0]  in_csra_wdata;
   logic [XLEN-1:0]  in_csrb_wdata;
   logic             mem_rvalid;
   logic [XLEN-1:0]  mem_rdata;
   logic             mem_rready;
   logic             pc_wen;
   logic             csra_wen;
   logic             csrb_wen;
   logic             gpr_wen;
   logic [XLEN-1:0]  new_pc;
   logic [11:0]      CSR_waddra;
   logic [11:0]      CSR_waddrb;
   logic [XLEN-1:0]  new_CSRa;
   logic [XLEN-1:0]  new_CSRb;
   logic [4:0]       GPR_waddr;
   logic [XLEN-1:0]  new_GPR;
   logic [CNT_W-1:0] retire_cnt;

   modport slave (
      input  in_valid, in_next_pc, in_gpr_wen, in_gpr_waddr, in_alu_result, in_is_load,
             in_load_funct3, in_addr_low, in_csra_wen, in_csrb_wen, in_csra_waddr,
             in_csrb_waddr, in_csra_wdata, in_csrb_wdata, mem_rvalid, mem_rdata,
      output in_ready, mem_rready, pc_wen, csra_wen, csrb_wen, gpr_wen, new_pc,
             CSR_waddra, CSR_waddrb, new_CSRa, new_CSRb, GPR_waddr, new_GPR, retire_cnt
   );

   modport master (
      output in_valid, in_next_pc, in_gpr_wen, in_gpr_waddr, in_alu_result, in_is_load,
             in_load_funct3, in_addr_low, in_csra_wen, in_csrb_wen, in_csra_waddr,
             in_csrb_waddr, in_csra_wdata, in_csrb_wdata, mem_rvalid, mem_rdata,
      input  in_ready, mem_rready, pc_wen, csra_wen, csrb_wen, gpr_wen, new_pc,
             CSR_waddra, CSR_waddrb, new_CSRa, new_CSRb, GPR_waddr, new_GPR, retire_cnt
   );
endinterface

// File: rtl/wb_commit.sv
// Write-back/commit stage: accepts one retiring instruction, waits for load data when
// needed, and emits a registered one-cycle commit strobe set plus a retire counter.
module wb_commit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input logic        clock,
   input logic        reset,
   wb_commit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

   state_t           state;
   logic             in_ready_q;
   logic             mem_rready_q;
   logic             accept;

   // Instruction fields held across the wait for load data
   logic [XLEN-1:0]  hold_pc_p0;
   logic             hold_gpr_wen_p0;
   logic [4:0]       hold_gpr_waddr_p0;
   logic [2:0]       hold_funct3_p0;
   logic [1:0]       hold_addr_low_p0;
   logic             hold_csra_wen_p0;
   logic             hold_csrb_wen_p0;
   logic [11:0]      hold_csra_waddr_p0;
   logic [11:0]      hold_csrb_waddr_p0;
   logic [XLEN-1:0]  hold_csra_wdata_p0;
   logic [XLEN-1:0]  hold_csrb_wdata_p0;

   logic             commit_go;
   logic             from_mem;
   logic [XLEN-1:0]  c_pc;
   logic             c_gpr_wen;
   logic [4:0]       c_gpr_waddr;
   logic [XLEN-1:0]  c_gpr_data;
   logic             c_csra_wen;
   logic             c_csrb_wen;
   logic [11:0]      c_csra_waddr;
   logic [11:0]      c_csrb_waddr;
   logic [XLEN-1:0]  c_csra_wdata;
   logic [XLEN-1:0]  c_csrb_wdata;

   logic             pc_wen_p1;
   logic             gpr_wen_p1;
   logic             csra_wen_p1;
   logic             csrb_wen_p1;
   logic [XLEN-1:0]  new_pc_p1;
   logic [4:0]       gpr_waddr_p1;
   logic [XLEN-1:0]  new_gpr_p1;
   logic [11:0]      csra_waddr_p1;
   logic [11:0]      csrb_waddr_p1;
   logic [XLEN-1:0]  new_csra_p1;
   logic [XLEN-1:0]  new_csrb_p1;
   logic [CNT_W-1:0] retire_cnt_p1;

   function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                   input logic [1:0]      addr_low,
                                                   input logic [XLEN-1:0] word);
      logic signed [7:0]  byte_s;
      logic signed [15:0] half_s;
      logic [XLEN-1:0]    res;
      byte_s = word[{addr_low, 3'b000} +: 8];
      half_s = addr_low[1] ? word[31:16] : word[15:0];
      case (funct3)
         3'd0:    res = {{(XLEN-8){byte_s[7]}}, byte_s};
         3'd1:    res = {{(XLEN-16){half_s[15]}}, half_s};
         3'd4:    res = {{(XLEN-8){1'b0}}, byte_s};
         3'd5:    res = {{(XLEN-16){1'b0}}, half_s};
         default: res = word;
      endcase
      return res;
   endfunction

   assign accept = bus.in_valid & in_ready_q;

   // A commit is sourced either straight from the execute stage (non-load accept)
   // or from the holding registers once the load beat arrives.
   always_comb begin
      from_mem     = (state == WAIT_MEM);
      commit_go    = from_mem ? bus.mem_rvalid : (accept & ~bus.in_is_load);
      c_pc         = from_mem ? hold_pc_p0         : bus.in_next_pc;
      c_gpr_wen    = from_mem ? hold_gpr_wen_p0    : bus.in_gpr_wen;
      c_gpr_waddr  = from_mem ? hold_gpr_waddr_p0  : bus.in_gpr_waddr;
      c_gpr_data   = from_mem ? load_extend(hold_funct3_p0, hold_addr_low_p0, bus.mem_rdata)
                              : bus.in_alu_result;
      c_csra_wen   = from_mem ? hold_csra_wen_p0   : bus.in_csra_wen;
      c_csrb_wen   = from_mem ? hold_csrb_wen_p0   : bus.in_csrb_wen;
      c_csra_waddr = from_mem ? hold_csra_waddr_p0 : bus.in_csra_waddr;
      c_csrb_waddr = from_mem ? hold_csrb_waddr_p0 : bus.in_csrb_waddr;
      c_csra_wdata = from_mem ? hold_csra_wdata_p0 : bus.in_csra_wdata;
      c_csrb_wdata = from_mem ? hold_csrb_wdata_p0 : bus.in_csrb_wdata;
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         hold_pc_p0         <= bus.in_next_pc;
         hold_gpr_wen_p0    <= bus.in_gpr_wen;
         hold_gpr_waddr_p0  <= bus.in_gpr_waddr;
         hold_funct3_p0     <= bus.in_load_funct3;
         hold_addr_low_p0   <= bus.in_addr_low;
         hold_csra_wen_p0   <= bus.in_csra_wen;
         hold_csrb_wen_p0   <= bus.in_csrb_wen;
         hold_csra_waddr_p0 <= bus.in_csra_waddr;
         hold_csrb_waddr_p0 <= bus.in_csrb_waddr;
         hold_csra_wdata_p0 <= bus.in_csra_wdata;
         hold_csrb_wdata_p0 <= bus.in_csrb_wdata;
      end
   end

   // Commit register stage and FSM
   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         in_ready_q    <= 1'b1;
         mem_rready_q  <= 1'b0;
         pc_wen_p1     <= 1'b0;
         gpr_wen_p1    <= 1'b0;
         csra_wen_p1   <= 1'b0;
         csrb_wen_p1   <= 1'b0;
         new_pc_p1     <= '0;
         gpr_waddr_p1  <= '0;
         new_gpr_p1    <= '0;
         csra_waddr_p1 <= '0;
         csrb_waddr_p1 <= '0;
         new_csra_p1   <= '0;
         new_csrb_p1   <= '0;
         retire_cnt_p1 <= '0;
      end else begin
         pc_wen_p1   <= commit_go;
         gpr_wen_p1  <= commit_go & c_gpr_wen & (c_gpr_waddr != 5'd0);
         // Same-address dual CSR write: port B wins
         csra_wen_p1 <= commit_go & c_csra_wen & ~(c_csrb_wen & (c_csra_waddr == c_csrb_waddr));
         csrb_wen_p1 <= commit_go & c_csrb_wen;
         if (commit_go) begin
            new_pc_p1     <= c_pc;
            gpr_waddr_p1  <= c_gpr_waddr;
            new_gpr_p1    <= c_gpr_data;
            csra_waddr_p1 <= c_csra_waddr;
            csrb_waddr_p1 <= c_csrb_waddr;
            new_csra_p1   <= c_csra_wdata;
            new_csrb_p1   <= c_csrb_wdata;
            retire_cnt_p1 <= retire_cnt_p1 + CNT_W'(1);
         end
         case (state)
            IDLE, COMMIT: begin
               if (accept && bus.in_is_load) begin
                  state        <= WAIT_MEM;
                  in_ready_q   <= 1'b0;
                  mem_rready_q <= 1'b1;
               end else if (accept) begin
                  state <= COMMIT;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_MEM: begin
               if (bus.mem_rvalid) begin
                  state        <= COMMIT;
                  in_ready_q   <= 1'b1;
                  mem_rready_q <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               in_ready_q   <= 1'b1;
               mem_rready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.mem_rready = mem_rready_q;
   assign bus.pc_wen     = pc_wen_p1;
   assign bus.gpr_wen    = gpr_wen_p1;
   assign bus.csra_wen   = csra_wen_p1;
   assign bus.csrb_wen   = csrb_wen_p1;
   assign bus.new_pc     = new_pc_p1;
   assign bus.GPR_waddr  = gpr_waddr_p1;
   assign bus.new_GPR    = new_gpr_p1;
   assign bus.CSR_waddra = csra_waddr_p1;
   assign bus.CSR_waddrb = csrb_waddr_p1;
   assign bus.new_CSRa   = new_csra_p1;
   assign bus.new_CSRb   = new_csrb_p1;
   assign bus.retire_cnt = retire_cnt_p1;

endmodule
